// File: rtl/snitch_streamctl_source.sv
// snitch_streamctl_source: emits N continue tokens then one done token per posted stream job.
// SNITCH_STREAMCTL_CREDIT_EN gates continue tokens on SSR element credits. Rev 1.0
`default_nettype none

module snitch_streamctl_source #(
    parameter int unsigned JobDepth    = 4,
    parameter int unsigned LenWidth    = 16,
    parameter int unsigned CreditWidth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [LenWidth-1:0]    job_len_i,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic                   elem_valid_i,
    output logic                   elem_ready_o,
    output logic [CreditWidth-1:0] credit_o,
    output logic                   streamctl_valid_o,
    output logic                   streamctl_done_o,
    input  logic                   streamctl_ready_i,
    output logic                   busy_o
);

    localparam int unsigned PtrWidth = (JobDepth > 1) ? $clog2(JobDepth) : 1;
    localparam int unsigned CntWidth = $clog2(JobDepth + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [LenWidth-1:0] fifo_mem_q [JobDepth];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                fifo_empty, fifo_full, push, pop;
    logic [LenWidth-1:0] fifo_head;

    logic [1:0]          state_q, state_d;
    logic [LenWidth-1:0] rem_q, rem_d;
    logic                credit_ok, cont_hs;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(JobDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CntWidth'(JobDepth));
    assign job_ready_o = ~fifo_full;
    assign push        = job_valid_i & ~fifo_full;
    assign fifo_head   = fifo_mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= job_len_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rem_q   <= '0;
        end else if (flush_i) begin
            state_q <= StIdle;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        cont_hs = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    rem_d   = fifo_head;
                    state_d = (fifo_head != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (credit_ok && streamctl_ready_i) begin
                    cont_hs = 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == LenWidth'(1)) state_d = StDone;
                end
            end
            StDone: begin
                if (streamctl_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend on registered state only
    always_comb begin
        streamctl_valid_o = 1'b0;
        streamctl_done_o  = 1'b0;
        case (state_q)
            StRun:   streamctl_valid_o = credit_ok;
            StDone: begin
                streamctl_valid_o = 1'b1;
                streamctl_done_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_o = (state_q != StIdle) | ~fifo_empty;

`ifdef SNITCH_STREAMCTL_CREDIT_EN
    logic [CreditWidth-1:0] credit_q, credit_d;
    logic                   credit_max, elem_acc;

    assign credit_max   = (credit_q == '1);
    assign elem_ready_o = ~credit_max;
    assign elem_acc     = elem_valid_i & ~credit_max;
    assign credit_ok    = (credit_q != '0);
    assign credit_o     = credit_q;

    always_comb begin
        credit_d = credit_q;
        if (elem_acc && !cont_hs)      credit_d = credit_q + 1'b1;
        else if (!elem_acc && cont_hs) credit_d = credit_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q <= '0;
        end else if (flush_i) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end
`else
    logic unused_elem_valid;

    assign unused_elem_valid = elem_valid_i;
    assign elem_ready_o      = 1'b1;
    assign credit_ok         = 1'b1;
    assign credit_o          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_snitch_streamctl_source.sv
// tb_snitch_streamctl_source: directed scoreboard bench for the stream-control token source.
`default_nettype none

module tb_snitch_streamctl_source;

`ifdef SNITCH_STREAMCTL_CREDIT_EN
    localparam bit CRED = 1'b1;
`else
    localparam bit CRED = 1'b0;
`endif
    localparam int MAXC = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic [15:0] job_len_i;
    logic        job_valid_i;
    logic        job_ready_o;
    logic        elem_valid_i;
    logic        elem_ready_o;
    logic [3:0]  credit_o;
    logic        streamctl_valid_o;
    logic        streamctl_done_o;
    logic        streamctl_ready_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    bit q[$];
    int m_credit = 0;
    bit pend = 0, pend_done = 0, after_done = 0;

    always #5 clk = ~clk;

    snitch_streamctl_source #(
        .JobDepth(4), .LenWidth(16), .CreditWidth(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i),
        .job_len_i(job_len_i), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .elem_valid_i(elem_valid_i), .elem_ready_o(elem_ready_o), .credit_o(credit_o),
        .streamctl_valid_o(streamctl_valid_o), .streamctl_done_o(streamctl_done_o),
        .streamctl_ready_i(streamctl_ready_i), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: score this cycle's handshake, then advance to just after the next falling edge
    task automatic cyc();
        bit e, hs, have, inc, dec;
        e = 0; have = 0;
        if (after_done) chk("bubble_after_done", streamctl_valid_o, 0);
        if (pend) begin
            chk("hold_valid", streamctl_valid_o, 1);
            chk("hold_done", streamctl_done_o, pend_done);
        end
        hs = streamctl_valid_o && streamctl_ready_i;
        if (flush_i) begin
            q.delete();
            m_credit = 0; pend = 0; after_done = 0;
        end else begin
            if (hs) begin
                chk("token_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    have = 1;
                    chk("token_done", streamctl_done_o, e);
                end
            end
            if (CRED) begin
                inc = elem_valid_i && (m_credit != MAXC);
                dec = have && !e;
                if (inc && !dec)      m_credit++;
                else if (!inc && dec) m_credit--;
            end
            if (job_valid_i && job_ready_o) begin
                repeat (job_len_i) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            pend       = streamctl_valid_o && !streamctl_ready_i;
            pend_done  = streamctl_done_o;
            after_done = hs && streamctl_done_o;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("credit", credit_o, CRED ? m_credit : 0);
        chk("elem_ready", elem_ready_o, CRED ? (m_credit != MAXC) : 1);
    endtask

    task automatic push_job(input logic [15:0] len);
        job_len_i = len; job_valid_i = 1'b1;
        cyc();
        job_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && q.size() != 0; i++) cyc();
        chk(tag, q.size(), 0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50 && !streamctl_valid_o; i++) cyc();
        chk(tag, streamctl_valid_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lens [5];
        int  n;
        bit  saw_ready;
        lens = '{16'd1, 16'd2, 16'd0, 16'd1, 16'd3};
        rst_n = 1'b0; flush_i = 0; job_len_i = '0; job_valid_i = 0;
        elem_valid_i = 0; streamctl_ready_i = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", streamctl_valid_o, 0);
        chk("rst_done", streamctl_done_o, 0);
        chk("rst_credit", credit_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_job_ready", job_ready_o, 1);
        chk("rst_elem_ready", elem_ready_o, 1);
        rst_n = 1'b1;

        // len=3 with three element beats
        streamctl_ready_i = 1;
        push_job(16'd3);
        elem_valid_i = 1;
        repeat (3) cyc();
        elem_valid_i = 0;
        drain("s1_drain");
        chk("s1_busy_end", busy_o, 0);
        chk("s1_credit_end", credit_o, 0);

        // len=0: done token alone at t+2
        push_job(16'd0);
        chk("s2_t1_valid", streamctl_valid_o, 0);
        cyc();
        chk("s2_t2_valid", streamctl_valid_o, 1);
        chk("s2_t2_done", streamctl_done_o, 1);
        cyc();
        chk("s2_idle_valid", streamctl_valid_o, 0);
        chk("s2_idle_busy", busy_o, 0);
        chk("s2_queue", q.size(), 0);

        // len=2, no credit, stall stability
        streamctl_ready_i = 0;
        push_job(16'd2);
`ifdef SNITCH_STREAMCTL_CREDIT_EN
        for (int i = 0; i < 10; i++) begin
            chk("s3_no_credit_valid", streamctl_valid_o, 0);
            cyc();
        end
        elem_valid_i = 1;
        cyc();
        elem_valid_i = 0;
`endif
        wait_valid("s3_valid_up");
        for (int i = 0; i < 5; i++) begin
            chk("s3_stall_valid", streamctl_valid_o, 1);
            chk("s3_stall_done", streamctl_done_o, 0);
            cyc();
        end
        streamctl_ready_i = 1;
        elem_valid_i = 1;
        drain("s3_drain");
        elem_valid_i = 0;

        // back-to-back jobs against a stalled consumer
        streamctl_ready_i = 0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            job_len_i = lens[i % 5]; job_valid_i = 1;
            if (job_ready_o) n++;
            cyc();
        end
        job_valid_i = 0;
        chk("s4_accepted", n, 5);
        chk("s4_full_ready", job_ready_o, 0);
        chk("s4_busy", busy_o, 1);
        streamctl_ready_i = 1; elem_valid_i = 1;
        saw_ready = 0;
        for (int i = 0; i < 80 && q.size() != 0; i++) begin
            cyc();
            if (job_ready_o) saw_ready = 1;
        end
        chk("s4_drain", q.size(), 0);
        chk("s4_ready_back", saw_ready, 1);
        elem_valid_i = 0;

`ifdef SNITCH_STREAMCTL_CREDIT_EN
        // credit saturation and simultaneous beat/consume
        streamctl_ready_i = 0; elem_valid_i = 1;
        repeat (16) cyc();
        chk("s5_sat_credit", credit_o, 15);
        chk("s5_sat_elem_ready", elem_ready_o, 0);
        push_job(16'd2);
        wait_valid("s5_valid");
        streamctl_ready_i = 1;
        cyc();
        chk("s5_after_first", credit_o, 14);
        cyc();
        chk("s5_simul_hold", credit_o, 14);
        drain("s5_drain");
        elem_valid_i = 0;
`endif

        // flush mid-RUN with two jobs queued
        streamctl_ready_i = 0; elem_valid_i = 1;
        push_job(16'd5);
        elem_valid_i = 0;
        push_job(16'd2);
        push_job(16'd3);
        wait_valid("s6_valid");
        chk("s6_busy_before", busy_o, 1);
        flush_i = 1; job_valid_i = 1; job_len_i = 16'd7; streamctl_ready_i = 1;
        cyc();
        flush_i = 0; job_valid_i = 0; streamctl_ready_i = 0;
        chk("s6_flush_valid", streamctl_valid_o, 0);
        chk("s6_flush_busy", busy_o, 0);
        chk("s6_flush_credit", credit_o, 0);
        chk("s6_flush_job_ready", job_ready_o, 1);
        repeat (2) cyc();
        chk("s6_stays_idle", streamctl_valid_o, 0);
        streamctl_ready_i = 1; elem_valid_i = 1;
        push_job(16'd1);
        elem_valid_i = 0;
        drain("s6_drain");
        chk("s6_busy_end", busy_o, 0);

        // asynchronous reset in the middle of a job
        streamctl_ready_i = 0; elem_valid_i = 1;
        push_job(16'd3);
        wait_valid("s7_valid");
        rst_n = 1'b0;
        #1;
        chk("s7_rst_valid", streamctl_valid_o, 0);
        chk("s7_rst_done", streamctl_done_o, 0);
        chk("s7_rst_credit", credit_o, 0);
        chk("s7_rst_busy", busy_o, 0);
        chk("s7_rst_job_ready", job_ready_o, 1);
        chk("s7_rst_elem_ready", elem_ready_o, 1);
        q.delete();
        m_credit = 0; pend = 0; after_done = 0; elem_valid_i = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc();
        chk("s7_post_valid", streamctl_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
